// File: rtl/mstream_xpose_if.sv
// Matrix Stream link bundle: ingress row beats toward the card, egress row beats back to the host.
// The host end uses the master modport and the card end uses the slave modport.
interface mstream_xpose_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  ig_vld;
    logic                  ig_rdy;
    logic [DATA_WIDTH-1:0] ig_r0;
    logic [DATA_WIDTH-1:0] ig_r1;
    logic [DATA_WIDTH-1:0] ig_r2;
    logic                  eg_vld;
    logic                  eg_rdy;
    logic [DATA_WIDTH-1:0] eg_r0;
    logic [DATA_WIDTH-1:0] eg_r1;
    logic [DATA_WIDTH-1:0] eg_r2;

    modport master (
        output ig_vld, ig_r0, ig_r1, ig_r2,
        input  ig_rdy,
        input  eg_vld, eg_r0, eg_r1, eg_r2,
        output eg_rdy
    );

    modport slave (
        input  ig_vld, ig_r0, ig_r1, ig_r2,
        output ig_rdy,
        output eg_vld, eg_r0, eg_r1, eg_r2,
        input  eg_rdy
    );
endinterface

// File: rtl/mstream_xpose.sv
// 3x3 matrix transpose engine with a ping-pong pair of register banks.
// Define MSTREAM_XPOSE_STATS_EN to add the mtx_cnt completed-matrix counter port.
module mstream_xpose #(
    parameter int DATA_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    mstream_xpose_if.slave    ms
`ifdef MSTREAM_XPOSE_STATS_EN
    ,
    output logic [15:0]       mtx_cnt
`endif
);

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILL,
        BANK_FULL
    } bank_st_e;

    bank_st_e              bank_st_q [2];
    bank_st_e              bank_st_d [2];
    logic                  wr_sel_q, wr_sel_d;
    logic                  rd_sel_q, rd_sel_d;
    logic [1:0]            wr_beat_q, wr_beat_d;
    logic [1:0]            rd_beat_q, rd_beat_d;
    // Indexed [bank][row][column].
    logic [DATA_WIDTH-1:0] mem_q [2][3][3];
    logic [DATA_WIDTH-1:0] mem_d [2][3][3];

    logic ig_rdy;
    logic eg_vld;
    logic ig_fire;
    logic eg_fire;

    // ig_rdy looks only at registered bank state, so a freed bank is visible one cycle later.
    assign ig_rdy  = reset_n && (bank_st_q[wr_sel_q] != BANK_FULL);
    assign eg_vld  = (bank_st_q[rd_sel_q] == BANK_FULL);
    assign ig_fire = ms.ig_vld && ig_rdy;
    assign eg_fire = eg_vld && ms.eg_rdy;

    assign ms.ig_rdy = ig_rdy;
    assign ms.eg_vld = eg_vld;
    assign ms.eg_r0  = mem_q[rd_sel_q][0][rd_beat_q];
    assign ms.eg_r1  = mem_q[rd_sel_q][1][rd_beat_q];
    assign ms.eg_r2  = mem_q[rd_sel_q][2][rd_beat_q];

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        bank_st_d = bank_st_q;
        mem_d     = mem_q;
        wr_sel_d  = wr_sel_q;
        rd_sel_d  = rd_sel_q;
        wr_beat_d = wr_beat_q;
        rd_beat_d = rd_beat_q;

        if (ig_fire) begin
            mem_d[wr_sel_q][wr_beat_q][0] = ms.ig_r0;
            mem_d[wr_sel_q][wr_beat_q][1] = ms.ig_r1;
            mem_d[wr_sel_q][wr_beat_q][2] = ms.ig_r2;
            if (wr_beat_q == 2'd2) begin
                bank_st_d[wr_sel_q] = BANK_FULL;
                wr_beat_d           = 2'd0;
                wr_sel_d            = ~wr_sel_q;
            end else begin
                bank_st_d[wr_sel_q] = BANK_FILL;
                wr_beat_d           = wr_beat_q + 2'd1;
            end
        end

        // The write bank is never FULL and the read bank always is, so both updates never collide.
        if (eg_fire) begin
            if (rd_beat_q == 2'd2) begin
                bank_st_d[rd_sel_q] = BANK_EMPTY;
                rd_beat_d           = 2'd0;
                rd_sel_d            = ~rd_sel_q;
            end else begin
                rd_beat_d = rd_beat_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            bank_st_q <= '{default: BANK_EMPTY};
            // NOTE: the bank is reset because its contents drive eg_r* directly and must read 0 in reset.
            mem_q     <= '{default: '0};
            wr_sel_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
            wr_beat_q <= 2'd0;
            rd_beat_q <= 2'd0;
        end else begin
            bank_st_q <= bank_st_d;
            mem_q     <= mem_d;
            wr_sel_q  <= wr_sel_d;
            rd_sel_q  <= rd_sel_d;
            wr_beat_q <= wr_beat_d;
            rd_beat_q <= rd_beat_d;
        end
    end

`ifdef MSTREAM_XPOSE_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (eg_fire && (rd_beat_q == 2'd2)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mtx_cnt = cnt_q;
`endif

endmodule

// File: doc/mstream_xpose.md
# mstream_xpose

Card-side matrix transpose engine for the Matrix Stream interface. Accepts 3x3 matrices as three ingress row beats (`ig_*`), buffers them in a ping-pong register bank, and emits the transposed matrix as three egress row beats (`eg_*`). It sits directly behind the card end of the mstream link: it consumes the ingress channel and produces the egress channel back toward the host.

## Interface
- `DATA_WIDTH`, 8: width of one matrix element (each `r*` lane).
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `ig_vld` in 1: ingress beat valid.
- `ig_rdy` out 1: ingress ready.
- `ig_r0`, `ig_r1`, `ig_r2` in DATA_WIDTH each: ingress row k, elements A[k][0..2].
- `eg_vld` out 1: egress beat valid.
- `eg_rdy` in 1: egress ready.
- `eg_r0`, `eg_r1`, `eg_r2` out DATA_WIDTH each: egress row k of A^T, i.e. A[0][k], A[1][k], A[2][k].
- `mtx_cnt` out 16: completed-matrix counter (present only with `MSTREAM_XPOSE_STATS_EN`).

## Operation
- Handshake: a beat transfers when `vld && rdy` on a rising edge. Valid never depends on ready. Once asserted, `eg_vld` and `eg_r*` hold stable until accepted.
- Storage: two banks, B0 and B1, each holding 9 elements. Each bank has its own state: EMPTY, FILL, or FULL.
- Write side uses `wr_sel` (bank) and `wr_beat` (0..2).
  - An ingress accept stores `ig_r0..2` into bank[wr_sel] row `wr_beat`, then increments `wr_beat`.
  - The accept taking the bank from EMPTY to FILL moves its state to FILL.
  - On the accept with `wr_beat==2`: the bank becomes FULL, `wr_beat` returns to 0, and `wr_sel` toggles.
- `ig_rdy` is 1 when bank[wr_sel] is not FULL. It is driven from registered state only: there is no combinational path from `eg_rdy` to `ig_rdy`.
- Read side uses `rd_sel` (bank) and `rd_beat` (0..2).
  - `eg_vld` = (bank[rd_sel] is FULL).
  - `eg_rj` = bank[rd_sel][j][rd_beat], muxed directly from the bank registers.
  - An egress accept increments `rd_beat`. On the accept with `rd_beat==2`: the bank becomes EMPTY, `rd_beat` returns to 0, and `rd_sel` toggles.
- Simultaneous events:
  - Filling one bank while draining the other in the same cycle is legal and required.
  - When the last egress beat frees a bank in the same cycle that the other bank completes, both transitions take effect.
- Both banks FULL: `ig_rdy`=0. `ig_rdy` returns to 1 the cycle after the final egress beat of bank[rd_sel] is accepted; there is no same-cycle bypass.
- Arithmetic: no arithmetic on data; elements pass through bit-exact. Beat counters are 2 bits and never take the value 3.

## Timing
- Reset, while `reset_n`=0 at a clock edge:
  - All bank states go to EMPTY; `wr_sel`, `rd_sel`, `wr_beat` and `rd_beat` go to 0; bank contents clear to 0.
  - Outputs: `ig_rdy`=0 (forced low while in reset), `eg_vld`=0, `eg_r*`=0, `mtx_cnt`=0.
- First cycle after reset release: `ig_rdy`=1.
- Latency: `eg_vld` rises on the cycle after the third ingress beat of a matrix is accepted. That is 1 cycle from the last input beat to the first output beat.
- Throughput: with `eg_rdy`=1 continuously, 1 beat/cycle sustained in both directions. Ingress never stalls.
- Reset mid-operation discards any partial or FULL matrix. No `eg_vld` is produced for discarded data.
- `ig_vld` while `ig_rdy`=0 is ignored; the data is not captured.

## Configuration
- `MSTREAM_XPOSE_STATS_EN` defined:
  - Adds output `mtx_cnt[15:0]`, reset to 0.
  - Increments on each accepted final egress beat (`rd_beat==2`) and wraps from 0xFFFF to 0x0000.
- `MSTREAM_XPOSE_STATS_EN` not defined: port `mtx_cnt` and its counter are absent. All other behaviour is identical.

## Test plan
- Basic transpose: ingress rows (1,2,3), (4,5,6), (7,8,9) with `eg_rdy`=1 -> egress rows (1,4,7), (2,5,8), (3,6,9). `eg_vld` first high exactly 1 cycle after the 3rd ingress accept.
- Back-to-back: 4 matrices with `ig_vld`=1 and `eg_rdy`=1 continuous -> `ig_rdy` stays 1 throughout. 12 egress beats with no bubble after the first, and all data is correct.
- Backpressure: `eg_rdy`=0, push 7 beats -> 6 are accepted and `ig_rdy`=0 after the 6th. `eg_vld`=1 with `eg_r*`=(1,4,7) held stable. Raise `eg_rdy` -> after 3 egress accepts, `ig_rdy`=1 the following cycle and the 7th beat is accepted.
- Reset mid-matrix: accept 2 beats, pulse `reset_n`=0 for 1 cycle -> `eg_vld` stays 0. A subsequent full matrix (10..18) emits (10,13,16), (11,14,17), (12,15,18).
- Random ready: randomized `ig_vld`/`eg_rdy` over 200 matrices -> scoreboard shows an exact transpose for every matrix, and no `eg_r*` change occurs while `eg_vld`=1 and `eg_rdy`=0.
- Stats (`MSTREAM_XPOSE_STATS_EN`): 5 matrices -> `mtx_cnt`=5. Force the counter to 0xFFFF and complete 1 more matrix -> `mtx_cnt`=0.
